baseline_calib: RTL and testbench

BASELINE_CALIB -- requirements
Module: baseline_calib

---
 rtl/baseline_calib.sv | 204 ++++++++++++++++++++
 tb/tb_baseline_calib.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/baseline_calib.sv
// Baseline calibration: averages 2^CAL_FRAMES_LOG2 frames per taxel, then subtracts that baseline.
// Optional feature macro: BASELINE_DEADBAND_EN (forces RUN residuals below DEADBAND to zero).
module baseline_calib #(
   parameter int unsigned SW_WIRE_CNT     = 16,
   parameter int unsigned RD_WIRE_CNT     = 16,
   parameter int unsigned CAL_FRAMES_LOG2 = 3,
   parameter int unsigned DEADBAND        = 8
) (
   input  logic                           clk_in,
   input  logic                           rst_n_in,
   input  logic                           cal_start_in,
   input  logic [$clog2(SW_WIRE_CNT):0]   sw_in,
   input  logic [$clog2(RD_WIRE_CNT):0]   rd_in,
   input  logic [11:0]                    data_in,
   input  logic                           valid_in,
   output logic [$clog2(SW_WIRE_CNT):0]   sw_out,
   output logic [$clog2(RD_WIRE_CNT):0]   rd_out,
   output logic [11:0]                    data_out,
   output logic                           valid_out,
   output logic                           cal_busy_out,
   output logic                           cal_done_out
);

   localparam int unsigned SwW   = $clog2(SW_WIRE_CNT) + 1;
   localparam int unsigned RdW   = $clog2(RD_WIRE_CNT) + 1;
   localparam int unsigned Depth = SW_WIRE_CNT * RD_WIRE_CNT;
   localparam int unsigned AddrW = (Depth > 1) ? $clog2(Depth) : 1;
   localparam int unsigned AccW  = 12 + CAL_FRAMES_LOG2;
   localparam int unsigned FcW   = (CAL_FRAMES_LOG2 > 0) ? CAL_FRAMES_LOG2 : 1;

   localparam logic [SwW-1:0] SwCnt  = SwW'(SW_WIRE_CNT);
   localparam logic [RdW-1:0] RdCnt  = RdW'(RD_WIRE_CNT);
   localparam logic [SwW-1:0] SwLast = SwW'(SW_WIRE_CNT - 1);
   localparam logic [RdW-1:0] RdLast = RdW'(RD_WIRE_CNT - 1);
   localparam logic [FcW-1:0] FcLast = FcW'((1 << CAL_FRAMES_LOG2) - 1);

   typedef enum logic [1:0] {StUncal, StSync, StAccum, StRun} state_e;

   // Reset asserts asynchronously, releases two clocks after rst_n_in rises.
   logic [1:0] rst_sync_q;
   logic       rst_sync_n;

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         rst_sync_q <= 2'b00;
      end else begin
         rst_sync_q <= {rst_sync_q[0], 1'b1};
      end
   end

   assign rst_sync_n = rst_sync_q[1];

   state_e         state_q, state_d;
   logic [FcW-1:0] frame_q, frame_d;
   logic           done_q, done_d;
   logic           acc_en, acc_first;

   logic             in_range, is_first, is_last;
   logic [AddrW-1:0] addr;

   always_comb begin
      in_range = (sw_in < SwCnt) && (rd_in < RdCnt);
      is_first = in_range && (sw_in == '0) && (rd_in == '0);
      is_last  = in_range && (sw_in == SwLast) && (rd_in == RdLast);
      addr     = '0;
      if (in_range) begin
         addr = AddrW'(AddrW'(sw_in) * AddrW'(RD_WIRE_CNT) + AddrW'(rd_in));
      end
   end

   always_comb begin
      state_d   = state_q;
      frame_d   = frame_q;
      done_d    = 1'b0;
      acc_en    = 1'b0;
      acc_first = 1'b0;
      if (cal_start_in) begin
         // Restart wins over everything, including a completing sample.
         state_d = StSync;
         frame_d = '0;
      end else if (valid_in && in_range) begin
         case (state_q)
            StSync: begin
               if (is_first) begin
                  state_d   = StAccum;
                  frame_d   = '0;
                  acc_en    = 1'b1;
                  acc_first = 1'b1;
               end
            end
            StAccum: begin
               acc_en    = 1'b1;
               acc_first = (frame_q == '0);
               if (is_last) begin
                  if (frame_q == FcLast) begin
                     state_d = StRun;
                     frame_d = '0;
                     done_d  = 1'b1;
                  end else begin
                     frame_d = frame_q + FcW'(1);
                  end
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk_in or negedge rst_sync_n) begin
      if (!rst_sync_n) begin
         state_q <= StUncal;
         frame_q <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         frame_q <= frame_d;
         done_q  <= done_d;
      end
   end

   // Stage 1: memory read plus the sample's context.
   logic             s1_valid_q, s1_corr_q, s1_wr_q, s1_first_q;
   logic [SwW-1:0]   s1_sw_q;
   logic [RdW-1:0]   s1_rd_q;
   logic [11:0]      s1_data_q;
   logic [AddrW-1:0] s1_addr_q;

   always_ff @(posedge clk_in or negedge rst_sync_n) begin
      if (!rst_sync_n) begin
         s1_valid_q <= 1'b0;
         s1_corr_q  <= 1'b0;
         s1_wr_q    <= 1'b0;
         s1_first_q <= 1'b0;
         s1_sw_q    <= '0;
         s1_rd_q    <= '0;
         s1_data_q  <= '0;
         s1_addr_q  <= '0;
      end else begin
         s1_valid_q <= valid_in;
         s1_corr_q  <= (state_q == StRun) && in_range;
         s1_wr_q    <= acc_en;
         s1_first_q <= acc_first;
         s1_sw_q    <= sw_in;
         s1_rd_q    <= rd_in;
         s1_data_q  <= data_in;
         s1_addr_q  <= addr;
      end
   end

   logic [AccW-1:0] acc_mem [Depth];
   logic [AccW-1:0] acc_rd_q;
   logic [AccW-1:0] acc_sum;

   assign acc_sum = s1_first_q ? AccW'(s1_data_q) : acc_rd_q + AccW'(s1_data_q);

   // Each address appears once per frame, so the write never collides with a pending read.
   always_ff @(posedge clk_in) begin
      acc_rd_q <= acc_mem[addr];
      if (s1_wr_q) begin
         acc_mem[s1_addr_q] <= acc_sum;
      end
   end

   // Stage 2: baseline subtract with saturation at zero.
   logic [11:0] baseline, resid, out_d;

   always_comb begin
      baseline = acc_rd_q[AccW-1:CAL_FRAMES_LOG2];
      resid    = (s1_data_q >= baseline) ? (s1_data_q - baseline) : 12'd0;
`ifdef BASELINE_DEADBAND_EN
      if (resid < 12'(DEADBAND)) begin
         resid = 12'd0;
      end
`endif
      out_d = s1_corr_q ? resid : s1_data_q;
   end

   logic           valid_q;
   logic [11:0]    data_q;
   logic [SwW-1:0] sw_q;
   logic [RdW-1:0] rd_q;

   always_ff @(posedge clk_in or negedge rst_sync_n) begin
      if (!rst_sync_n) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         sw_q    <= '0;
         rd_q    <= '0;
      end else begin
         valid_q <= s1_valid_q;
         data_q  <= out_d;
         sw_q    <= s1_sw_q;
         rd_q    <= s1_rd_q;
      end
   end

   assign valid_out    = valid_q;
   assign data_out     = data_q;
   assign sw_out       = sw_q;
   assign rd_out       = rd_q;
   assign cal_done_out = done_q;
   assign cal_busy_out = (state_q == StSync) || (state_q == StAccum);

endmodule

// File: tb/tb_baseline_calib.sv
// Directed bench for baseline_calib: table vectors in RUN plus frame sequences for calibration.
module tb_baseline_calib;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       cs = 1'b0;
   logic       valid = 1'b0;
   logic [4:0] sw = '0, rd = '0;
   logic [11:0] din = '0;
   logic [4:0] sw_o, rd_o;
   logic [11:0] data_o;
   logic       valid_o, busy_o, done_o;

   int total = 0;
   int bad = 0;
   int done_cnt = 0;

`ifdef BASELINE_DEADBAND_EN
   localparam logic [11:0] Db = 12'd8;
`else
   localparam logic [11:0] Db = 12'd0;
`endif

   baseline_calib dut (
      .clk_in       (clk),
      .rst_n_in     (rst_n),
      .cal_start_in (cs),
      .sw_in        (sw),
      .rd_in        (rd),
      .data_in      (din),
      .valid_in     (valid),
      .sw_out       (sw_o),
      .rd_out       (rd_o),
      .data_out     (data_o),
      .valid_out    (valid_o),
      .cal_busy_out (busy_o),
      .cal_done_out (done_o)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (done_o) done_cnt++;

   typedef struct packed {
      logic        chk;
      logic        v;
      logic [4:0]  sw;
      logic [4:0]  rd;
      logic [11:0] e;
   } pend_t;

   pend_t pipe [2];

   typedef struct packed {
      logic [4:0]  sw;
      logic [4:0]  rd;
      logic [11:0] d;
      logic [11:0] e;
   } vec_t;

   vec_t tab [15];

   function automatic logic [11:0] dbf(input logic [11:0] r);
      return (r < Db) ? 12'd0 : r;
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d, want %0d", nm, act, exp);
      end
   endtask

   // Drives one cycle and checks the output of the sample driven two calls earlier.
   task automatic apply(input logic c, input logic [4:0] s, input logic [4:0] r,
                        input logic [11:0] d, input logic v, input logic ck,
                        input logic [11:0] e);
      if (pipe[1].chk) begin
         total++;
         if (valid_o !== pipe[1].v || (pipe[1].v && (data_o !== pipe[1].e ||
             sw_o !== pipe[1].sw || rd_o !== pipe[1].rd))) begin
            bad++;
            $display("FAIL pipe sw=%0d rd=%0d: got v=%0d d=%0d sw=%0d rd=%0d, want v=%0d d=%0d",
                     pipe[1].sw, pipe[1].rd, valid_o, data_o, sw_o, rd_o, pipe[1].v, pipe[1].e);
         end
      end
      pipe[1] = pipe[0];
      pipe[0] = '{chk: ck, v: v, sw: s, rd: r, e: e};
      cs = c;
      sw = s;
      rd = r;
      din = d;
      valid = v;
      @(posedge clk);
      #1;
   endtask

   task automatic flush();
      apply(1'b0, 5'd0, 5'd0, 12'd0, 1'b0, 1'b0, 12'd0);
      apply(1'b0, 5'd0, 5'd0, 12'd0, 1'b0, 1'b0, 12'd0);
   endtask

   // One frame: special taxel (ssw,srd) gets d_sp, others d_oth; corrected expectations apply
   // up to and including the cal_start sample, raw afterwards.
   task automatic frame(input logic [11:0] d_oth, input int ssw, input int srd,
                        input logic [11:0] d_sp, input bit corr, input logic [11:0] e_oth,
                        input logic [11:0] e_sp, input int cs_idx, input int n);
      for (int i = 0; i < n; i++) begin
         logic [11:0] d, e;
         bit sp;
         sp = ((i / 16) == ssw) && ((i % 16) == srd);
         d  = sp ? d_sp : d_oth;
         if (corr && (cs_idx < 0 || i <= cs_idx)) e = sp ? e_sp : e_oth;
         else e = d;
         apply((i == cs_idx), 5'(i / 16), 5'(i % 16), d, 1'b1, 1'b1, e);
      end
   endtask

   initial begin
      pipe[0] = '0;
      pipe[1] = '0;
      // Baseline A: others 50, (3,5) 200.  Baseline B: others 30, (4,4) 0.
      tab[0]  = '{sw: 5'd0,  rd: 5'd0,  d: 12'd40,   e: 12'd0};
      tab[1]  = '{sw: 5'd3,  rd: 5'd5,  d: 12'd207,  e: dbf(12'd7)};
      tab[2]  = '{sw: 5'd3,  rd: 5'd5,  d: 12'd208,  e: 12'd8};
      tab[3]  = '{sw: 5'd3,  rd: 5'd5,  d: 12'd200,  e: 12'd0};
      tab[4]  = '{sw: 5'd1,  rd: 5'd2,  d: 12'd51,   e: dbf(12'd1)};
      tab[5]  = '{sw: 5'd15, rd: 5'd15, d: 12'd4095, e: 12'd4045};
      tab[6]  = '{sw: 5'd16, rd: 5'd3,  d: 12'd123,  e: 12'd123};
      tab[7]  = '{sw: 5'd2,  rd: 5'd16, d: 12'd77,   e: 12'd77};
      tab[8]  = '{sw: 5'd31, rd: 5'd31, d: 12'd9,    e: 12'd9};
      tab[9]  = '{sw: 5'd4,  rd: 5'd4,  d: 12'd4095, e: 12'd4095};
      tab[10] = '{sw: 5'd0,  rd: 5'd0,  d: 12'd30,   e: 12'd0};
      tab[11] = '{sw: 5'd0,  rd: 5'd1,  d: 12'd31,   e: dbf(12'd1)};
      tab[12] = '{sw: 5'd4,  rd: 5'd4,  d: 12'd0,    e: 12'd0};
      tab[13] = '{sw: 5'd9,  rd: 5'd9,  d: 12'd29,   e: 12'd0};
      tab[14] = '{sw: 5'd3,  rd: 5'd5,  d: 12'd260,  e: 12'd230};

      repeat (3) @(posedge clk);
      #1;
      chk("rst valid", valid_o, 0);
      chk("rst data", data_o, 0);
      chk("rst sw", sw_o, 0);
      chk("rst rd", rd_o, 0);
      chk("rst busy", busy_o, 0);
      chk("rst done", done_o, 0);
      rst_n = 1'b1;
      repeat (4) @(posedge clk);
      #1;

      // Uncalibrated passthrough
      frame(12'd100, 0, 0, 12'd100, 1'b0, 12'd0, 12'd0, -1, 256);
      flush();
      chk("uncal busy", busy_o, 0);

      // Calibration A
      done_cnt = 0;
      apply(1'b1, 5'd0, 5'd0, 12'd0, 1'b0, 1'b1, 12'd0);
      chk("sync busy", busy_o, 1);
      for (int f = 0; f < 7; f++) frame(12'd50, 3, 5, 12'd200, 1'b0, 12'd0, 12'd0, -1, 256);
      chk("accA busy", busy_o, 1);
      chk("accA no done", done_cnt, 0);
      frame(12'd50, 3, 5, 12'd200, 1'b0, 12'd0, 12'd0, -1, 256);
      chk("calA done", done_o, 1);
      chk("calA busy", busy_o, 0);
      frame(12'd50, 3, 5, 12'd260, 1'b1, 12'd0, 12'd60, -1, 256);
      chk("calA done once", done_cnt, 1);
      for (int i = 0; i < 9; i++) apply(1'b0, tab[i].sw, tab[i].rd, tab[i].d, 1'b1, 1'b1, tab[i].e);
      flush();

      // Mid-frame restart at (7,2): exactly 8 more frames needed
      done_cnt = 0;
      frame(12'd50, 3, 5, 12'd260, 1'b1, 12'd0, 12'd60, 7 * 16 + 2, 256);
      chk("restart busy", busy_o, 1);
      for (int f = 0; f < 7; f++) frame(12'd30, 4, 4, 12'd0, 1'b0, 12'd0, 12'd0, -1, 256);
      chk("accB no done", done_cnt, 0);
      chk("accB busy", busy_o, 1);
      frame(12'd30, 4, 4, 12'd0, 1'b0, 12'd0, 12'd0, -1, 256);
      chk("calB done", done_o, 1);
      for (int i = 9; i < 15; i++) apply(1'b0, tab[i].sw, tab[i].rd, tab[i].d, 1'b1, 1'b1, tab[i].e);
      flush();
      chk("calB done once", done_cnt, 1);

      // cal_start on the completing sample wins
      done_cnt = 0;
      apply(1'b1, 5'd0, 5'd0, 12'd0, 1'b0, 1'b1, 12'd0);
      for (int f = 0; f < 7; f++) frame(12'd30, 4, 4, 12'd0, 1'b0, 12'd0, 12'd0, -1, 256);
      frame(12'd30, 4, 4, 12'd0, 1'b0, 12'd0, 12'd0, 255, 256);
      flush();
      chk("coincide no done", done_cnt, 0);
      chk("coincide busy", busy_o, 1);

      // Reset in ACCUM frame 4
      for (int f = 0; f < 4; f++) frame(12'd30, 4, 4, 12'd0, 1'b0, 12'd0, 12'd0, -1, 256);
      frame(12'd30, 4, 4, 12'd0, 1'b0, 12'd0, 12'd0, -1, 40);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid rst valid", valid_o, 0);
      chk("mid rst data", data_o, 0);
      chk("mid rst sw", sw_o, 0);
      chk("mid rst busy", busy_o, 0);
      chk("mid rst done", done_o, 0);
      pipe[0].chk = 1'b0;
      pipe[1].chk = 1'b0;
      valid = 1'b0;
      cs = 1'b0;
      repeat (2) @(posedge clk);
      #3;
      rst_n = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      chk("post rst busy", busy_o, 0);
      apply(1'b0, 5'd3, 5'd5, 12'd260, 1'b1, 1'b1, 12'd260);
      apply(1'b0, 5'd16, 5'd0, 12'd500, 1'b1, 1'b1, 12'd500);
      apply(1'b0, 5'd15, 5'd15, 12'd31, 1'b1, 1'b1, 12'd31);
      flush();
      chk("post rst idle busy", busy_o, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
